// File: rtl/hamming_secded_decoder.sv
// hamming_secded_decoder
// Two-stage pipelined SECDED decoder that sits at the end of the banked memory
// read path. Stage 1 computes the Hamming syndrome and overall parity. Stage 2
// corrects single-bit errors, flags uncorrectable words and extracts the data.
// The two stages form a valid/ready pipeline that sustains one word per cycle.
// Optional feature macro: SECDED_ERR_CNT_EN adds saturating error counters.
// When it is undefined, both counters read 0 and i_clr_cnt is ignored.
`timescale 1ns/1ps

module hamming_secded_decoder #(
  parameter int DATA_WIDTH   = 8,
  parameter int PARITY_BITS  = $clog2(DATA_WIDTH) + 1,
  parameter int ENCODED_WORD = DATA_WIDTH + PARITY_BITS,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [ENCODED_WORD+1:1] i_word,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic                    o_sec,
  output logic                    o_ded,
  output logic                    o_valid,
  input  logic                    i_ready,
  input  logic                    i_clr_cnt,
  output logic [CNT_WIDTH-1:0]    o_sec_cnt,
  output logic [CNT_WIDTH-1:0]    o_ded_cnt
);

  // Codeword position that holds data bit k. Data bits occupy the
  // non-power-of-two positions in ascending order.
  function automatic int data_pos(input int k);
    int cnt;
    data_pos = 0;
    cnt      = 0;
    for (int p = 1; p <= ENCODED_WORD; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == k) data_pos = p;
        cnt++;
      end
    end
  endfunction

  // Stage 1 state
  logic                    r_s1_valid;
  logic [ENCODED_WORD:1]   r_s1_word;
  logic [PARITY_BITS-1:0]  r_s1_syn;
  logic                    r_s1_par;

  // Stage 2 state (the output registers)
  logic                    r_valid;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_sec;
  logic                    r_ded;

  logic                    w_s1_load;
  logic                    w_s2_load;
  logic [PARITY_BITS-1:0]  w_syn;
  logic                    w_par;
  logic                    w_in_range;
  logic                    w_syn_nz;
  logic                    w_sec;
  logic                    w_ded;
  logic                    w_flip_en;
  logic [ENCODED_WORD:1]   w_corr;
  logic [DATA_WIDTH-1:0]   w_data;
  logic                    w_unused;

  // Stage 2 advances when its slot is free or being consumed; stage 1 advances
  // when empty or when its word moves on. o_ready therefore follows i_ready
  // combinationally once the pipeline is full.
  assign w_s2_load = !r_valid || i_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign o_ready   = w_s1_load;

  // Syndrome: XOR of the indices of every set bit in the Hamming positions.
  always_comb begin
    w_syn = '0;
    for (int i = 1; i <= ENCODED_WORD; i++) begin
      if (i_word[i]) w_syn = w_syn ^ PARITY_BITS'(i);
    end
  end

  // Overall parity includes the extra parity bit, so a clean word gives 0.
  assign w_par = ^i_word;

  // Stage 1 register: capture the word and its check results on acceptance.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_word  <= '0;
      r_s1_syn   <= '0;
      r_s1_par   <= 1'b0;
    end else if (w_s1_load) begin
      r_s1_valid <= i_valid;
      if (i_valid) begin
        r_s1_word <= i_word[ENCODED_WORD:1];
        r_s1_syn  <= w_syn;
        r_s1_par  <= w_par;
      end
    end
  end

  // Decision: odd parity with an in-range syndrome is a single error (S=0
  // means the overall parity bit itself flipped). Anything else with a
  // non-zero syndrome is uncorrectable and the word passes through unflipped.
  assign w_in_range = (r_s1_syn <= PARITY_BITS'(ENCODED_WORD));
  assign w_syn_nz   = |r_s1_syn;
  assign w_sec      = r_s1_par & w_in_range;
  assign w_ded      = w_syn_nz & (~r_s1_par | ~w_in_range);
  assign w_flip_en  = r_s1_par & w_syn_nz & w_in_range;

  genvar gi;
  generate
    for (gi = 1; gi <= ENCODED_WORD; gi++) begin : g_corr
      assign w_corr[gi] = r_s1_word[gi] ^ (w_flip_en && (r_s1_syn == PARITY_BITS'(gi)));
    end
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_extract
      localparam int POS = data_pos(gi);
      assign w_data[gi] = w_corr[POS];
    end
  endgenerate

  // Stage 2 register: holds data and flags stable while the consumer stalls.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sec   <= 1'b0;
      r_ded   <= 1'b0;
    end else if (w_s2_load) begin
      r_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_data <= w_data;
        r_sec  <= w_sec;
        r_ded  <= w_ded;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_sec   = r_sec;
  assign o_ded   = r_ded;

`ifdef SECDED_ERR_CNT_EN
  logic [CNT_WIDTH-1:0] r_sec_cnt;
  logic [CNT_WIDTH-1:0] r_ded_cnt;
  logic                 w_out_hs;

  assign w_out_hs = r_valid & i_ready;

  // Saturating error counters; a clear takes priority over an increment.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sec_cnt <= '0;
      r_ded_cnt <= '0;
    end else if (i_clr_cnt) begin
      r_sec_cnt <= '0;
      r_ded_cnt <= '0;
    end else if (w_out_hs) begin
      if (r_sec && (r_sec_cnt != '1)) r_sec_cnt <= r_sec_cnt + CNT_WIDTH'(1);
      if (r_ded && (r_ded_cnt != '1)) r_ded_cnt <= r_ded_cnt + CNT_WIDTH'(1);
    end
  end

  assign o_sec_cnt = r_sec_cnt;
  assign o_ded_cnt = r_ded_cnt;
  // Check-bit positions of the corrected word carry no data.
  assign w_unused  = ^w_corr;
`else
  assign o_sec_cnt = '0;
  assign o_ded_cnt = '0;
  // Check-bit positions carry no data; the clear input has nothing to clear.
  assign w_unused  = ^{w_corr, i_clr_cnt};
`endif

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Self-checking bench for hamming_secded_decoder (DATA_WIDTH=8, 13-bit word).
// Table of hand-derived vectors plus hand-written backpressure, reset and
// counter sequences. Expected outputs go through a scoreboard queue.
`timescale 1ns/1ps

module tb_hamming_secded_decoder;

  localparam int DW = 8;
  localparam int EW = 12;
  localparam int CW = 16;
`ifdef SECDED_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  localparam int SAT_WORDS = CNT_EN ? (1 << CW) + 3 : 40;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [EW+1:1] i_word;
  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] o_data;
  logic          o_sec;
  logic          o_ded;
  logic          o_valid;
  logic          i_ready;
  logic          i_clr_cnt;
  logic [CW-1:0] o_sec_cnt;
  logic [CW-1:0] o_ded_cnt;

  hamming_secded_decoder #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_word(i_word), .i_valid(i_valid),
    .o_ready(o_ready), .o_data(o_data), .o_sec(o_sec), .o_ded(o_ded),
    .o_valid(o_valid), .i_ready(i_ready), .i_clr_cnt(i_clr_cnt),
    .o_sec_cnt(o_sec_cnt), .o_ded_cnt(o_ded_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          sec;
    logic          ded;
  } exp_t;

  typedef struct {
    string         name;
    logic [EW+1:1] word;
    logic [DW-1:0] data;
    logic          sec;
    logic          ded;
  } vec_t;

  exp_t          sb_q[$];
  exp_t          cur_exp;
  int            errors = 0;
  int            checks = 0;
  int            n_in = 0;
  int            n_out = 0;
  int            stalls = 0;
  bit            quiet = 1'b0;
  logic [CW-1:0] m_sec_cnt = '0;
  logic [CW-1:0] m_ded_cnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference encoder: places data, then computes each check bit from the
  // positions it covers, then the overall even parity bit.
  function automatic logic [EW+1:1] enc(input logic [DW-1:0] d);
    logic [EW+1:1] w;
    int            k;
    logic          p;
    w = '0;
    k = 0;
    for (int pos = 1; pos <= EW; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        w[pos] = d[k];
        k++;
      end
    end
    for (int c = 1; c <= EW; c = c * 2) begin
      p = 1'b0;
      for (int pos = 1; pos <= EW; pos++)
        if (((pos & c) != 0) && (pos != c)) p = p ^ w[pos];
      w[c] = p;
    end
    w[EW+1] = ^w[EW:1];
    return w;
  endfunction

  // Monitor / scoreboard: pops on output handshake, pushes on input handshake,
  // and tracks the expected counter values from the expected flags.
  always @(negedge i_clk) begin
    exp_t e;
    bit   hs;
    bit   have_e;
    if (i_rst) begin
      m_sec_cnt = '0;
      m_ded_cnt = '0;
    end else begin
      hs     = o_valid && i_ready;
      have_e = 1'b0;
      if (hs) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got data=%02h with empty scoreboard, expected no output", o_data);
        end else begin
          e      = sb_q.pop_front();
          have_e = 1'b1;
          n_out++;
          if (!quiet)
            $display("out #%0d data=%02h sec=%0b ded=%0b (exp %02h %0b %0b)",
                     n_out, o_data, o_sec, o_ded, e.data, e.sec, e.ded);
          chk("out_data", 32'(o_data), 32'(e.data));
          chk("out_sec", 32'(o_sec), 32'(e.sec));
          chk("out_ded", 32'(o_ded), 32'(e.ded));
        end
      end
      if (CNT_EN) begin
        if (i_clr_cnt) begin
          m_sec_cnt = '0;
          m_ded_cnt = '0;
        end else if (have_e) begin
          if (e.sec && m_sec_cnt != 16'hFFFF) m_sec_cnt = m_sec_cnt + 16'd1;
          if (e.ded && m_ded_cnt != 16'hFFFF) m_ded_cnt = m_ded_cnt + 16'd1;
        end
      end
      if (i_valid && o_ready) begin
        sb_q.push_back(cur_exp);
        n_in++;
      end
    end
  end

  // Present one word and hold it until accepted (bounded).
  task automatic send(input logic [EW+1:1] w, input exp_t e);
    bit done;
    int guard;
    done    = 1'b0;
    guard   = 0;
    i_word  = w;
    i_valid = 1'b1;
    cur_exp = e;
    while (!done) begin
      @(negedge i_clk);
      if (o_ready) done = 1'b1;
      else stalls++;
      @(posedge i_clk);
      #1;
      guard++;
      if (!done && guard > 50) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got o_ready=0 for 50 cycles, expected acceptance");
        done = 1'b1;
      end
    end
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb_q.size() != 0 && g < 100) begin
      @(posedge i_clk);
      #1;
      g++;
    end
    chk("drain_pending", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic chk_cnt(input string tag);
    @(negedge i_clk);
    chk({tag, "_sec_cnt"}, 32'(o_sec_cnt), 32'(m_sec_cnt));
    chk({tag, "_ded_cnt"}, 32'(o_ded_cnt), 32'(m_ded_cnt));
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no finish by 1.5 ms, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          vecs[10];
    exp_t          e;
    exp_t          bp_e[4];
    logic [EW+1:1] bp_w[4];
    logic [EW+1:1] w;
    logic [DW-1:0] d;
    int            base;
    int            g;

    vecs[0] = '{"clean_a5",      13'h0A27, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{"sec_data_b6",   13'h0A07, 8'hA5, 1'b1, 1'b0};
    vecs[2] = '{"sec_overall",   13'h1A27, 8'hA5, 1'b1, 1'b0};
    vecs[3] = '{"ded_b6_b10",    13'h0807, 8'h81, 1'b0, 1'b1};
    vecs[4] = '{"ded_syn15",     13'h0224, 8'h25, 1'b0, 1'b1};
    vecs[5] = '{"clean_zero",    13'h0000, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{"clean_ff",      13'h0F77, 8'hFF, 1'b0, 1'b0};
    vecs[7] = '{"sec_check_b8",  13'h0FF7, 8'hFF, 1'b1, 1'b0};
    vecs[8] = '{"sec_check_b1",  13'h0A26, 8'hA5, 1'b1, 1'b0};
    vecs[9] = '{"ded_b3_b5",     13'h0A33, 8'hA6, 1'b0, 1'b1};

    i_rst = 1'b1; i_valid = 1'b0; i_word = '0; i_ready = 1'b1; i_clr_cnt = 1'b0;
    cur_exp = '{8'h00, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_sec", 32'(o_sec), 32'd0);
    chk("rst_ded", 32'(o_ded), 32'd0);
    chk("rst_sec_cnt", 32'(o_sec_cnt), 32'd0);
    chk("rst_ded_cnt", 32'(o_ded_cnt), 32'd0);
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_ready", 32'(o_ready), 32'd1);
    @(posedge i_clk);
    #1;

    // Latency: driven in cycle c, o_valid first seen in cycle c+2
    i_word = 13'h0A27; i_valid = 1'b1; cur_exp = '{8'hA5, 1'b0, 1'b0};
    @(negedge i_clk);
    chk("lat_accept", 32'(o_ready), 32'd1);
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    @(negedge i_clk);
    chk("lat_c1_valid", 32'(o_valid), 32'd0);
    @(posedge i_clk);
    #1;
    @(negedge i_clk);
    chk("lat_c2_valid", 32'(o_valid), 32'd1);
    @(posedge i_clk);
    #1;
    drain();

    // Table of vectors, streamed back to back
    stalls = 0;
    foreach (vecs[i]) begin
      $display("in  %s word=%04h", vecs[i].name, vecs[i].word);
      e = '{vecs[i].data, vecs[i].sec, vecs[i].ded};
      send(vecs[i].word, e);
    end
    drain();
    chk("stream_stalls", 32'(stalls), 32'd0);
    chk_cnt("table");

    // Backpressure: i_ready low for 3 cycles while streaming 4 words
    bp_w[0] = enc(8'h3C) ^ 13'h0010;   // position 5 flipped
    bp_e[0] = '{8'h3C, 1'b1, 1'b0};
    bp_w[1] = enc(8'h5A) ^ 13'h0104;   // positions 3 and 9 flipped
    bp_e[1] = '{8'h4B, 1'b0, 1'b1};
    bp_w[2] = enc(8'hC3);
    bp_e[2] = '{8'hC3, 1'b0, 1'b0};
    bp_w[3] = enc(8'h0F) ^ 13'h1000;   // overall parity flipped
    bp_e[3] = '{8'h0F, 1'b1, 1'b0};
    base = n_out;
    i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_word = bp_w[k]; i_valid = 1'b1; cur_exp = bp_e[k];
      @(negedge i_clk);
      if (k < 2) begin
        chk("bp_ready_open", 32'(o_ready), 32'd1);
      end else begin
        chk("bp_ready_full", 32'(o_ready), 32'd0);
        chk("bp_hold_valid", 32'(o_valid), 32'd1);
        chk("bp_hold_data", 32'(o_data), 32'(bp_e[0].data));
        chk("bp_hold_sec", 32'(o_sec), 32'(bp_e[0].sec));
      end
      @(posedge i_clk);
      #1;
    end
    i_ready = 1'b1;
    @(negedge i_clk);
    chk("bp_ready_rise", 32'(o_ready), 32'd1);
    @(posedge i_clk);
    #1;
    send(bp_w[3], bp_e[3]);
    drain();
    chk("bp_delivered", 32'(n_out - base), 32'd4);
    chk("bp_in_out_match", 32'(n_in), 32'(n_out));

    // Reset with both stages full: discarded immediately, nothing emerges
    send(enc(8'h77), '{8'h77, 1'b0, 1'b0});
    send(enc(8'h88), '{8'h88, 1'b0, 1'b0});
    chk("midrst_pre_valid", 32'(o_valid), 32'd1);
    i_rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(o_valid), 32'd0);
    sb_q.delete();
    n_in = n_out;
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      chk("midrst_no_output", 32'(o_valid), 32'd0);
      @(posedge i_clk);
      #1;
    end
    chk_cnt("midrst");

    // Saturation: stream of single-error words
    quiet = 1'b1;
    for (int n = 0; n < SAT_WORDS; n++) begin
      d = 8'($urandom);
      w = enc(d);
      w[$urandom_range(13, 1)] ^= 1'b1;
      send(w, '{d, 1'b1, 1'b0});
    end
    drain();
    quiet = 1'b0;
    $display("sat stream of %0d words done", SAT_WORDS);
    @(negedge i_clk);
    chk("sat_sec_cnt", 32'(o_sec_cnt), CNT_EN ? 32'hFFFF : 32'h0);
    @(posedge i_clk);
    #1;
    chk_cnt("sat");

    // Clear asserted in the same cycle as an error handshake
    w = enc(8'h12) ^ 13'h0003;         // positions 1 and 2 flipped
    send(w, '{8'h12, 1'b0, 1'b1});
    drain();
    chk_cnt("pre_clr");
    i_ready = 1'b0;
    send(w, '{8'h12, 1'b0, 1'b1});
    g = 0;
    while (!o_valid && g < 10) begin
      @(posedge i_clk);
      #1;
      g++;
    end
    chk("clr_wait_valid", 32'(o_valid), 32'd1);
    i_clr_cnt = 1'b1;
    i_ready   = 1'b1;
    @(posedge i_clk);
    #1 i_clr_cnt = 1'b0;
    @(negedge i_clk);
    chk("clr_sec_cnt", 32'(o_sec_cnt), 32'd0);
    chk("clr_ded_cnt", 32'(o_ded_cnt), 32'd0);
    @(posedge i_clk);
    #1;
    drain();
    chk_cnt("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
